// File: rtl/instr_boot_loader_pkg.sv
// Shared types and constants for the instruction boot loader.
// Latency: none (declarations only).
// Backpressure: n/a.
package instr_boot_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_CPU_RST = 3'd2,
    ST_STREAM  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // acc holds lane+1 bytes right-justified; move them to the top of the word
  // so a short final word is zero-padded in its low bytes.
  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] acc,
                                                 input logic [LANE_W-1:0] lane);
    return acc << (BYTE_W * (LANES - 1 - int'(lane)));
  endfunction

endpackage

// File: rtl/instr_boot_loader_word_buffer.sv
// Program word store: register array with write/read pointers, registered read.
// Latency: write visible to a read on the next edge; read data one cycle after rd_en.
// Backpressure: writes ignored once full; caller owns flow control via wr_cnt.
module boot_word_buffer
  import instr_boot_loader_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_dat,
  output logic [CNT_W:0]    wr_cnt,
  output logic [CNT_W:0]    rd_cnt
);

  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(MAX_WORDS);
  localparam logic [CNT_W:0] ONE   = (CNT_W+1)'(1);

  logic [WORD_W-1:0] mem_q [MAX_WORDS];
  logic [CNT_W:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W:0]    rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0] rd_dat_q, rd_dat_d;
  logic              full;
  logic              wr_go;

  assign full   = (wr_ptr_q == DEPTH);
  assign wr_go  = wr_en && !full && !clr;
  assign rd_dat = rd_dat_q;
  assign wr_cnt = wr_ptr_q;
  assign rd_cnt = rd_ptr_q;

  // Pointer advance and read-data select; read data is zero when not reading.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_dat_d = '0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_en) begin
        rd_dat_d = mem_q[rd_ptr_q[CNT_W-1:0]];
        rd_ptr_d = rd_ptr_q + ONE;
      end
    end
  end

  // Pointer and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  // Storage array; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q[CNT_W-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/instr_boot_loader.sv
// Packs a byte stream into 32-bit words, buffers the program, then loads it into the CPU.
// Latency: last byte accepted -> first LoadInstructions 2 cycles; one word per cycle streamed.
// Backpressure: byte_ready high only in FILL while the buffer has room; drops after last byte.
module instr_boot_loader
  import instr_boot_loader_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              LoadInstructions,
  output logic [31:0]       Instruction,
  output logic              CpuReset,
  output logic              busy,
  output logic              done,
  output logic [CNT_W:0]    word_count
);

  localparam logic [CNT_W:0] LAST_SLOT = (CNT_W+1)'(MAX_WORDS - 1);
  localparam int             ACC_W     = WORD_W - BYTE_W;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                byte_ready_q, byte_ready_d;
  logic                load_q, load_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic [WORD_W-1:0]   word_in;
  logic                buf_clr, buf_wr, buf_rd;
  logic [WORD_W-1:0]   buf_wdat, buf_rdat;
  logic [CNT_W:0]      buf_wr_cnt, buf_rd_cnt;

  assign accept   = byte_valid && byte_ready_q;
  assign word_in  = {acc_q, byte_data};
  assign buf_wdat = pad_word(word_in, lane_q);

  boot_word_buffer #(
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (Reset),
    .clr    (buf_clr),
    .wr_en  (buf_wr),
    .wr_dat (buf_wdat),
    .rd_en  (buf_rd),
    .rd_dat (buf_rdat),
    .wr_cnt (buf_wr_cnt),
    .rd_cnt (buf_rd_cnt)
  );

  // Next state, byte packing and buffer control; outputs are derived from the
  // next state so every port comes straight off a flop.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FILL;
          buf_clr = 1'b1;
          lane_d  = '0;
        end
      end
      ST_FILL: begin
        if (accept) begin
          acc_d  = word_in[ACC_W-1:0];
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3 || byte_last) begin
            buf_wr = 1'b1;
            lane_d = '0;
          end
          // Leave on the final byte or when this write fills the last slot.
          if (byte_last || (lane_q == 2'd3 && buf_wr_cnt == LAST_SLOT)) state_d = ST_CPU_RST;
        end
      end
      ST_CPU_RST: state_d = ST_STREAM;
      ST_STREAM:  if (buf_rd_cnt == buf_wr_cnt) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
    buf_rd       = (state_d == ST_STREAM);
    byte_ready_d = (state_d == ST_FILL);
    load_d       = (state_d == ST_STREAM);
    cpu_reset_d  = !(state_d == ST_STREAM || state_d == ST_DONE);
    busy_d       = (state_d == ST_FILL) || (state_d == ST_CPU_RST) ||
                   (state_d == ST_STREAM) || (state_d == ST_RELEASE);
    done_d       = (state_d == ST_DONE);
  end

  // State, packer and output registers; reset keeps the CPU held in reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      acc_q        <= '0;
      byte_ready_q <= 1'b0;
      load_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      byte_ready_q <= byte_ready_d;
      load_q       <= load_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready       = byte_ready_q;
  assign LoadInstructions = load_q;
  assign Instruction      = buf_rdat;
  assign CpuReset         = cpu_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign word_count       = buf_wr_cnt;

endmodule

// File: tb/tb_instr_boot_loader.sv
module tb_instr_boot_loader;

  localparam int MAXW = 32;
  localparam int MAXB = MAXW * 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic        CpuReset;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;

  instr_boot_loader #(.MAX_WORDS(MAXW), .CNT_W(5)) dut (
    .clk              (clk),
    .Reset            (Reset),
    .start            (start),
    .byte_data        (byte_data),
    .byte_valid       (byte_valid),
    .byte_last        (byte_last),
    .byte_ready       (byte_ready),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .CpuReset         (CpuReset),
    .busy             (busy),
    .done             (done),
    .word_count       (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_q[$];

  // monitor / CPU-side model state
  logic [31:0] obs_q[$];
  int          li_cnt;
  int          cyc = 0;
  int          last_cyc;
  int          first_li_cyc;
  bit          prev_li;
  bit          saw_release;
  int          ld_ctr;
  logic [31:0] imem [MAXW];

  always @(posedge clk) cyc++;

  // Observe mid-cycle: byte handshakes, streamed words, and a CPU whose load
  // counter is cleared by CpuReset and advanced by LoadInstructions.
  always @(negedge clk) begin
    if (byte_valid && byte_ready && byte_last) last_cyc = cyc;
    if (LoadInstructions) begin
      if (li_cnt == 0) first_li_cyc = cyc;
      obs_q.push_back(Instruction);
      li_cnt++;
    end
    if (prev_li && !LoadInstructions && CpuReset && busy && Instruction == 32'h0) saw_release = 1'b1;
    prev_li = LoadInstructions;
    if (CpuReset) ld_ctr = 0;
    else if (LoadInstructions) begin
      imem[ld_ctr % MAXW] = Instruction;
      ld_ctr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    li_cnt       = 0;
    last_cyc     = -100;
    first_li_cyc = -1;
    saw_release  = 1'b0;
  endtask

  // Reference: accepted bytes are the first min(n, MAXB); packed big-endian,
  // final partial word zero-filled in its low bytes.
  task automatic build_model(input int n);
    int acc_n;
    acc_n = (n > MAXB) ? MAXB : n;
    exp_q.delete();
    for (int i = 0; i < (acc_n + 3) / 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < acc_n; i++)
      exp_q[i / 4] = exp_q[i / 4] | (32'(stim[i]) << (8 * (3 - (i % 4))));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cpu_reset", 32'(CpuReset), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_word_count", 32'(word_count), 32'd0);
    chk("start_byte_ready", 32'(byte_ready), 32'd1);
  endtask

  task automatic feed(input bit use_last, input bit gaps, input bit poke, output int accepted);
    int idx = 0;
    int stall = 0;
    bit go;
    while (idx < stim.size() && stall < 8) begin
      byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      byte_data  = stim[idx];
      byte_last  = use_last && (idx == stim.size() - 1);
      start      = poke && (idx == 2);
      go         = byte_valid && byte_ready;
      if (!byte_ready) stall++;
      tick();
      start = 1'b0;
      if (go) begin
        idx++;
        stall = 0;
      end
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    accepted   = idx;
  endtask

  task automatic finish_load(input int n, input bit use_last, input bit poke);
    int  t = 0;
    bit  poked = 1'b0;
    int  m;
    while (!done && t < 400) begin
      start = poke && !poked && (li_cnt > 0);
      if (start) poked = 1'b1;
      tick();
      start = 1'b0;
      t++;
    end
    chk("done_within_bound", 32'(t < 400), 32'd1);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cpu_reset", 32'(CpuReset), 32'd0);
    chk("done_load_low", 32'(LoadInstructions), 32'd0);
    chk("done_instr_zero", Instruction, 32'h0);
    chk("word_count", 32'(word_count), 32'(exp_q.size()));
    chk("load_cycles", 32'(li_cnt), 32'(exp_q.size()));
    chk("release_cycle", 32'(saw_release), 32'd1);
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("stream_word%0d", k), obs_q[k], exp_q[k]);
      chk($sformatf("cpu_imem%0d", k), imem[k], exp_q[k]);
    end
    if (use_last && n <= MAXB)
      chk("last_to_load_latency", 32'(first_li_cyc - last_cyc), 32'd2);
  endtask

  task automatic run_load(input int n, input logic [7:0] first, input logic [7:0] step,
                          input bit use_last, input bit rnd, input bit gaps,
                          input bit poke, input bit with_start);
    int acc;
    stim.delete();
    for (int i = 0; i < n; i++)
      stim.push_back(rnd ? 8'($urandom) : 8'(int'(first) + i * int'(step)));
    build_model(n);
    clear_mon();
    if (with_start) do_start();
    feed(use_last, gaps, poke, acc);
    chk("bytes_accepted", 32'(acc), 32'((n > MAXB) ? MAXB : n));
    finish_load(n, use_last, poke);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          use_last;
    int          exp_wc;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acc;
    int n;
    bit ul;

    vecs[0] = '{8,   8'h01, 8'h01, 1'b1, 2,  32'h01020304, 32'h05060708};
    vecs[1] = '{6,   8'hAA, 8'h11, 1'b1, 2,  32'hAABBCCDD, 32'hEEFF0000};
    vecs[2] = '{1,   8'h5A, 8'h00, 1'b1, 1,  32'h5A000000, 32'h0};
    vecs[3] = '{5,   8'h10, 8'h01, 1'b1, 2,  32'h10111213, 32'h14000000};
    vecs[4] = '{7,   8'h21, 8'h01, 1'b1, 2,  32'h21222324, 32'h25262700};
    vecs[5] = '{140, 8'h00, 8'h01, 1'b0, 32, 32'h00010203, 32'h04050607};

    Reset = 1'b0; start = 1'b0; byte_data = 8'h0; byte_valid = 1'b0; byte_last = 1'b0;
    prev_li = 1'b0; ld_ctr = 0;
    for (int i = 0; i < MAXW; i++) imem[i] = 32'h0;
    clear_mon();
    repeat (3) tick();
    chk("rst_cpu_reset", 32'(CpuReset), 32'd1);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_load", 32'(LoadInstructions), 32'd0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    Reset = 1'b1;
    tick();
    chk("idle_cpu_reset", 32'(CpuReset), 32'd1);
    chk("idle_byte_ready", 32'(byte_ready), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // start with a byte offered in the same IDLE cycle: the byte must not be taken
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h99; byte_last = 1'b1;
    chk("idle_start_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    chk("idle_byte_not_taken_wc", 32'(word_count), 32'd0);
    chk("idle_byte_not_taken_fill", 32'(byte_ready), 32'd1);
    run_load(4, 8'hC0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_pair_word0", obs_q.size() > 0 ? obs_q[0] : 32'hDEAD, 32'hC0C1C2C3);

    // table-driven loads with hand-computed expectations
    foreach (vecs[i]) begin
      run_load(vecs[i].n, vecs[i].first, vecs[i].step, vecs[i].use_last, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("vec%0d_wc", i), 32'(word_count), 32'(vecs[i].exp_wc));
      chk($sformatf("vec%0d_w0", i), obs_q.size() > 0 ? obs_q[0] : 32'hDEAD, vecs[i].exp_w0);
      if (vecs[i].exp_wc > 1)
        chk($sformatf("vec%0d_w1", i), obs_q.size() > 1 ? obs_q[1] : 32'hDEAD, vecs[i].exp_w1);
    end
    chk("full_last_word", obs_q.size() == MAXW ? obs_q[MAXW-1] : 32'hDEAD, 32'h7C7D7E7F);

    // start pulses during FILL and STREAM must be ignored
    run_load(48, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // reset during the fourth streamed word, then a clean reload
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(8'($urandom));
    build_model(40);
    clear_mon();
    do_start();
    feed(1'b1, 1'b0, 1'b0, acc);
    for (int t = 0; t < 50 && obs_q.size() < 4; t++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_stream_reached", 32'(obs_q.size()), 32'd4);
    chk("mid_stream_word3", obs_q.size() > 3 ? obs_q[3] : 32'hDEAD, exp_q[3]);
    Reset = 1'b0;
    #1;
    chk("midrst_cpu_reset", 32'(CpuReset), 32'd1);
    chk("midrst_load", 32'(LoadInstructions), 32'd0);
    chk("midrst_instr", Instruction, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    run_load(13, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // randomized loads with random valid gaps
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        n  = $urandom_range(MAXB + 1, MAXB + 20);
        ul = 1'($urandom_range(0, 1));
      end else begin
        n  = $urandom_range(1, 60);
        ul = 1'b1;
      end
      run_load(n, 8'h00, 8'h00, ul, 1'b1, 1'b1, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
